// File: rtl/connect_net2_arb.sv
// connect_net2_arb: round-robin owner arbiter for a shared two-net connection with a guard gap
module connect_net2_arb #(
    parameter int MAXLEN = 16,
    parameter int GUARD  = 1,
    localparam int LW = $clog2(MAXLEN + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          reqA__ENA,
    input  logic [LW-1:0] reqA_len,
    output logic          reqA__RDY,
    input  logic          reqB__ENA,
    input  logic [LW-1:0] reqB_len,
    output logic          reqB__RDY,
    input  logic [1:0]    A_IN,
    input  logic [1:0]    B_IN,
    output logic [1:0]    A_OUT,
    output logic [1:0]    B_OUT,
    output logic          IN1,
    output logic          IN2,
    input  logic          OUT1,
    input  logic          OUT2,
    output logic          grantA,
    output logic          grantB,
    output logic          busy
);
    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
    localparam logic [LW-1:0] MAX_L = LW'(MAXLEN);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, GRD} state_t;

    state_t        state_q, state_d;
    logic          pend_a_q, pend_a_d, pend_b_q, pend_b_d, last_b_q, last_b_d;
    logic [LW-1:0] len_a_q, len_a_d, len_b_q, len_b_d, cnt_q, cnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          take_a, take_b;

    function automatic logic [LW-1:0] clamp(input logic [LW-1:0] l);
        return (l == '0) ? LW'(1) : (l > MAX_L) ? MAX_L : l;
    endfunction

    assign grantA    = state_q == GNT_A;
    assign grantB    = state_q == GNT_B;
    assign busy      = state_q != IDLE;
    assign reqA__RDY = !pend_a_q && !grantA && !RST;
    assign reqB__RDY = !pend_b_q && !grantB && !RST;
    assign take_a    = reqA__ENA && reqA__RDY;
    assign take_b    = reqB__ENA && reqB__RDY;
    assign {IN2, IN1} = grantA ? A_IN : grantB ? B_IN : 2'b00;
    assign A_OUT     = grantA ? {OUT2, OUT1} : 2'b00;
    assign B_OUT     = grantB ? {OUT2, OUT1} : 2'b00;

    // Latch requests, pick the next owner round-robin, and count burst and guard cycles
    always_comb begin
        state_d  = state_q;
        pend_a_d = pend_a_q || take_a;
        pend_b_d = pend_b_q || take_b;
        len_a_d  = take_a ? clamp(reqA_len) : len_a_q;
        len_b_d  = take_b ? clamp(reqB_len) : len_b_q;
        last_b_d = last_b_q;
        cnt_d    = cnt_q;
        gcnt_d   = gcnt_q;
        case (state_q)
            IDLE: begin
                if (pend_a_q && (!pend_b_q || last_b_q)) begin
                    state_d  = GNT_A;
                    pend_a_d = 1'b0;
                    cnt_d    = len_a_q;
                    last_b_d = 1'b0;
                end else if (pend_b_q) begin
                    state_d  = GNT_B;
                    pend_b_d = 1'b0;
                    cnt_d    = len_b_q;
                    last_b_d = 1'b1;
                end
            end
            GNT_A, GNT_B: begin
                cnt_d = cnt_q - LW'(1);
                if (cnt_q == LW'(1)) begin
                    state_d = (GUARD == 0) ? IDLE : GRD;
                    gcnt_d  = GW'(GUARD);
                end
            end
            default: begin
                gcnt_d = gcnt_q - GW'(1);
                if (gcnt_q == GW'(1)) state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops any burst in flight immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            len_a_q  <= '0;
            len_b_q  <= '0;
            last_b_q <= 1'b1;
            cnt_q    <= '0;
            gcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            len_a_q  <= len_a_d;
            len_b_q  <= len_b_d;
            last_b_q <= last_b_d;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
        end
    end
endmodule

// File: tb/tb_connect_net2_arb.sv
// tb_connect_net2_arb: directed checks of grant timing, fairness, clamping, reset and zero-guard build
module tb_connect_net2_arb;
    localparam int LW = 5;

    logic          CLK = 1'b0, RST = 1'b1;
    logic          a_ena = 1'b0, b_ena = 1'b0, a0_ena = 1'b0, b0_ena = 1'b0;
    logic [LW-1:0] a_len = '0, b_len = '0, a0_len = '0, b0_len = '0;
    logic [1:0]    a_in = 2'b10, b_in = 2'b01;
    logic          out1 = 1'b1, out2 = 1'b1;
    logic          a_rdy, b_rdy, in1, in2, ga, gb, busy;
    logic [1:0]    a_out, b_out;
    logic          a0_rdy, b0_rdy, in1_0, in2_0, ga0, gb0, busy0;
    logic [1:0]    a0_out, b0_out;
    int            vecs = 0, errs = 0, n;

    connect_net2_arb #(.MAXLEN(16), .GUARD(1)) dut (
        .CLK(CLK), .RST(RST),
        .reqA__ENA(a_ena), .reqA_len(a_len), .reqA__RDY(a_rdy),
        .reqB__ENA(b_ena), .reqB_len(b_len), .reqB__RDY(b_rdy),
        .A_IN(a_in), .B_IN(b_in), .A_OUT(a_out), .B_OUT(b_out),
        .IN1(in1), .IN2(in2), .OUT1(out1), .OUT2(out2),
        .grantA(ga), .grantB(gb), .busy(busy)
    );

    connect_net2_arb #(.MAXLEN(16), .GUARD(0)) dut0 (
        .CLK(CLK), .RST(RST),
        .reqA__ENA(a0_ena), .reqA_len(a0_len), .reqA__RDY(a0_rdy),
        .reqB__ENA(b0_ena), .reqB_len(b0_len), .reqB__RDY(b0_rdy),
        .A_IN(a_in), .B_IN(b_in), .A_OUT(a0_out), .B_OUT(b0_out),
        .IN1(in1_0), .IN2(in2_0), .OUT1(out1), .OUT2(out2),
        .grantA(ga0), .grantB(gb0), .busy(busy0)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2;
        chk("rst_rdyA", a_rdy, 0);
        chk("rst_rdyB", b_rdy, 0);
        chk("rst_grants", {ga, gb}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in", {in2, in1}, 0);
        chk("rst_outs", {a_out, b_out}, 0);
        tick(); tick();
        RST = 1'b0;
        #1;
        chk("rel_rdyA", a_rdy, 1);
        chk("rel_rdyB", b_rdy, 1);
        // A alone, len 3
        tick(); a_ena = 1'b1; a_len = 3;
        tick(); a_ena = 1'b0;
        chk("a1_t1_rdy", a_rdy, 0);
        chk("a1_t1_gnt", ga, 0);
        tick();
        chk("a1_t2_gnt", ga, 1);
        chk("a1_t2_in", {in2, in1}, 2'b10);
        chk("a1_t2_aout", a_out, 2'b11);
        chk("a1_t2_bout", b_out, 0);
        chk("a1_t2_busy", busy, 1);
        a_in = 2'b01;
        #1;
        chk("a1_t2_in_follow", {in2, in1}, 2'b01);
        tick(); chk("a1_t3_gnt", ga, 1);
        tick(); chk("a1_t4_gnt", ga, 1); chk("a1_t4_rdy", a_rdy, 0);
        tick();
        chk("a1_t5_gnt", ga, 0);
        chk("a1_t5_busy", busy, 1);
        chk("a1_t5_in", {in2, in1}, 0);
        chk("a1_t5_rdy", a_rdy, 1);
        tick(); chk("a1_t6_busy", busy, 0);
        // tie after reset: A wins, B follows after the gap
        RST = 1'b1; #1; RST = 1'b0;
        a_ena = 1'b1; b_ena = 1'b1; a_len = 2; b_len = 2;
        tick(); a_ena = 1'b0; b_ena = 1'b0;
        tick();
        chk("tie_t2_gA", ga, 1);
        chk("tie_t2_gB", gb, 0);
        chk("tie_t2_bout", b_out, 0);
        tick(); chk("tie_t3_gA", ga, 1);
        tick();
        chk("tie_t4_grants", {ga, gb}, 0);
        chk("tie_t4_busy", busy, 1);
        chk("tie_t4_rdyA", a_rdy, 1);
        chk("tie_t4_rdyB", b_rdy, 0);
        tick(); chk("tie_t5_busy", busy, 0);
        tick();
        chk("tie_t6_gB", gb, 1);
        chk("tie_t6_in", {in2, in1}, 2'b01);
        chk("tie_t6_bout", b_out, 2'b11);
        chk("tie_t6_aout", a_out, 0);
        tick(); chk("tie_t7_gB", gb, 1);
        tick(); chk("tie_t8_gB", gb, 0);
        tick();
        // length clamping
        a_ena = 1'b1; a_len = 0;
        tick(); a_ena = 1'b0;
        n = 0;
        repeat (6) begin tick(); n += int'(ga); end
        chk("len0_cycles", n, 1);
        a_ena = 1'b1; a_len = 21;
        tick(); a_ena = 1'b0;
        n = 0;
        repeat (30) begin tick(); n += int'(ga); end
        chk("lenmax_cycles", n, 16);
        // fairness: A, B, A with A re-requesting at first RDY
        a_ena = 1'b1; a_len = 4;
        tick(); a_ena = 1'b0;
        tick(); chk("rr_t2_gA", ga, 1); b_ena = 1'b1; b_len = 2;
        tick(); b_ena = 1'b0; chk("rr_t3_rdyB", b_rdy, 0);
        tick(); tick();
        chk("rr_t5_gA", ga, 1);
        chk("rr_t5_rdyA", a_rdy, 0);
        tick();
        chk("rr_t6_gA", ga, 0);
        chk("rr_t6_rdyA", a_rdy, 1);
        a_ena = 1'b1; a_len = 1;
        tick(); a_ena = 1'b0; chk("rr_t7_busy", busy, 0);
        tick(); chk("rr_t8_grants", {ga, gb}, 2'b01);
        tick(); chk("rr_t9_gB", gb, 1);
        tick(); chk("rr_t10_gB", gb, 0);
        tick(); chk("rr_t11_busy", busy, 0);
        tick(); chk("rr_t12_grants", {ga, gb}, 2'b10);
        tick(); chk("rr_t13_gA", ga, 0);
        tick();
        // reset in the second cycle of a B burst
        b_ena = 1'b1; b_len = 5;
        tick(); b_ena = 1'b0;
        tick(); chk("rst_mid_t2_gB", gb, 1);
        tick();
        #2; RST = 1'b1; #1;
        chk("rst_mid_gB", gb, 0);
        chk("rst_mid_in", {in2, in1}, 0);
        chk("rst_mid_bout", b_out, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rdy", {a_rdy, b_rdy}, 0);
        #1; RST = 1'b0; #1;
        chk("rst_mid_rel_rdy", {a_rdy, b_rdy}, 2'b11);
        a_ena = 1'b1; b_ena = 1'b1; a_len = 1; b_len = 1;
        tick(); a_ena = 1'b0; b_ena = 1'b0;
        tick(); chk("rst_mid_tie", {ga, gb}, 2'b10);
        tick(); tick();
        // zero-guard build: owner-to-owner gap is one idle cycle
        a0_ena = 1'b1; b0_ena = 1'b1; a0_len = 2; b0_len = 2;
        tick(); a0_ena = 1'b0; b0_ena = 1'b0;
        tick(); chk("g0_t2_gA", ga0, 1);
        tick(); chk("g0_t3_gA", ga0, 1);
        tick();
        chk("g0_t4_grants", {ga0, gb0}, 0);
        chk("g0_t4_busy", busy0, 0);
        tick(); chk("g0_t5_gB", gb0, 1);
        tick(); chk("g0_t6_gB", gb0, 1);
        tick(); chk("g0_t7_gB", gb0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
